ssa_combine: RTL and testbench
==============================

# ssa_combine

Carry-propagating recombiner for the SSA multiplier datapath, the inverse of the digit splitter. It accepts a packed vector of convolution coefficients, one per 2-bit digit position with zero-padded headroom, and folds them serially into a single binary product. It evaluates sum(coef[k] << 2k) one coefficient per cycle, with a valid/ready handshake on both sides. It sits between the pointwise-product/inverse-transform stage and the product output register.

## Interface
- DIGIT_W, 2: digit width in bits; coefficient k carries weight 2^(DIGIT_W*k).
- COEF_W, 12: width of each coefficient slot.
- NCOEF, 7: number of coefficients; 2*4-1 for an 8-bit × 8-bit product.
- OUT_W, 16: product width.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  coefficient vector valid.
- in_ready  output  1  block can accept a vector.
- in  input  NCOEF*COEF_W  coefficients; coef[k] = in[k*COEF_W +: COEF_W]; coef[0] is least significant.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- out  output  OUT_W  recombined product.
- ovf  output  1  product did not fit in OUT_W. Present only with SSA_COMBINE_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch `in` into the coefficient shift register, clear the carry (COEF_W+1 bits) and the result register, set k=0, and go to RUN.
- RUN, one step per cycle:
  - sum = carry + coef[k], COEF_W+1 bits; this cannot overflow.
  - result[DIGIT_W*k +: DIGIT_W] = sum[DIGIT_W-1:0].
  - carry = sum >> DIGIT_W.
  - Shift the coefficient register down by one slot.
  - k == NCOEF-1 → DONE.
- Entering DONE: result bits above DIGIT_W*NCOEF take the low OUT_W-DIGIT_W*NCOEF bits of the final carry (16-14 = 2 bits at defaults).
  - If any remaining carry bit is nonzero, the overflow condition is set. `out` is truncated regardless.
- DONE:
  - out_valid=1. `out` and ovf are held stable until out_ready.
  - On out_ready → IDLE.
- No new input is accepted while in RUN or DONE (in_ready=0). `in` is ignored outside the IDLE handshake.
- Reset, asynchronous and valid at any time including mid-RUN:
  - state=IDLE, carry=0, result=0, k=0.
  - in_ready=0 while rst is asserted, 1 after release.
  - out_valid=0, out=0, ovf=0.
  - A partially processed vector is discarded.

## Timing
- An input handshake in cycle T (in_valid & in_ready) puts the FSM in RUN at T+1.
- RUN steps occur in cycles T+1 … T+NCOEF.
- out_valid rises at T+NCOEF+1 (T+8 at defaults). Latency is NCOEF+1 cycles.
- Output handshake in cycle U (out_valid & out_ready): state is IDLE at U+1, in_ready=1 at U+1, and the next vector can be accepted at U+1.
  - Throughput is one product per NCOEF+2 cycles with out_ready held high.
- in_ready is combinational from state only, never from in_valid.
- out_valid, out and ovf are registered.
- out_ready asserted before out_valid has no effect.
- out_valid never drops without a handshake or reset.

## Configuration
- SSA_COMBINE_OVF_EN defined:
  - The ovf port exists.
  - ovf is registered on entry to DONE: 1 iff (final carry >> (OUT_W-DIGIT_W*NCOEF)) != 0.
  - ovf is held with `out` and cleared on reset and on the output handshake.
- Not defined:
  - No ovf port and no overflow compare logic.
  - `out` is silently truncated to OUT_W bits; all other behaviour is identical.

## Test plan
- Max product: in_valid with coef = {9,18,27,36,27,18,9} (coef[0]=9) → out=65025 (0xFE01) exactly 8 cycles after the accept; ovf=0.
- Unit: coef[0]=1, all others 0 → out=1. Then coef[3]=5, all others 0 → out=5<<6=320.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out, out_valid and ovf stay stable and in_ready stays 0. Asserting out_ready for 1 cycle → in_ready=1 in the next cycle.
- Overflow (macro on): coef[6]=4095, all others 0 → out=(4095<<12) mod 65536 = 0xF000, ovf=1. Macro off: same out, no ovf port.
- Reset mid-RUN: assert rst 3 cycles after the accept → out_valid=0, out=0 and in_ready=0 immediately; after release, in_ready=1. The next vector {9,18,27,36,27,18,9} gives 65025 with no stale carry.
- Back-to-back: in_valid held high with out_ready=1 → vectors are accepted every 9 cycles, and in_valid is ignored while in RUN or DONE.

Source files
------------

// File: rtl/ssa_combine.sv
// Serial carry-propagating recombiner: folds NCOEF convolution coefficients into one binary product.
// Optional overflow flag output is enabled by defining SSA_COMBINE_OVF_EN.
module ssa_combine #(
    parameter int DIGIT_W = 2,
    parameter int COEF_W  = 12,
    parameter int NCOEF   = 7,
    parameter int OUT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCOEF*COEF_W-1:0]  in,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef SSA_COMBINE_OVF_EN
    output logic                     ovf,
`endif
    output logic [OUT_W-1:0]         out
);

    localparam int KW    = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int RES_W = DIGIT_W * NCOEF;
    localparam int HI_W  = OUT_W - RES_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [NCOEF*COEF_W-1:0]   coef_q, coef_d;
    logic [COEF_W:0]           carry_q, carry_d;
    logic [RES_W-1:0]          result_q, result_d;
    logic [KW-1:0]             k_q, k_d;
    logic [OUT_W-1:0]          out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic [COEF_W:0]           sum;
`ifdef SSA_COMBINE_OVF_EN
    logic                      ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        carry_d     = carry_q;
        result_d    = result_q;
        k_d         = k_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sum         = '0;
`ifdef SSA_COMBINE_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    coef_d   = in;
                    carry_d  = '0;
                    result_d = '0;
                    k_d      = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Carry stays below 2^COEF_W, so one extra bit holds the sum without loss.
                sum = carry_q + {1'b0, coef_q[COEF_W-1:0]};
                result_d[DIGIT_W*k_q +: DIGIT_W] = sum[DIGIT_W-1:0];
                carry_d = sum >> DIGIT_W;
                coef_d  = coef_q >> COEF_W;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NCOEF-1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_d       = {carry_d[HI_W-1:0], result_d};
`ifdef SSA_COMBINE_OVF_EN
                    ovf_d       = |(carry_d >> HI_W);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
`ifdef SSA_COMBINE_OVF_EN
                    ovf_d       = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            coef_q      <= '0;
            carry_q     <= '0;
            result_q    <= '0;
            k_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef SSA_COMBINE_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            k_q         <= k_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef SSA_COMBINE_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Held low during reset even though the state register already reads IDLE.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out       = out_q;
`ifdef SSA_COMBINE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ssa_combine.sv
// Directed bench for ssa_combine: latency, unit vectors, backpressure, overflow, reset mid-run, back-to-back.
module tb_ssa_combine;

    localparam int COEF_W = 12;
    localparam int NCOEF  = 7;
    localparam int OUT_W  = 16;
    localparam int VEC_W  = NCOEF * COEF_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [VEC_W-1:0]  in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out;
`ifdef SSA_COMBINE_OVF_EN
    logic              ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ssa_combine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SSA_COMBINE_OVF_EN
        .ovf       (ovf),
`endif
        .out       (out)
    );

    function automatic logic [VEC_W-1:0] vec7(input int c0, input int c1, input int c2,
                                              input int c3, input int c4, input int c5,
                                              input int c6);
        logic [VEC_W-1:0] v;
        v = '0;
        v[0*COEF_W +: COEF_W] = c0[COEF_W-1:0];
        v[1*COEF_W +: COEF_W] = c1[COEF_W-1:0];
        v[2*COEF_W +: COEF_W] = c2[COEF_W-1:0];
        v[3*COEF_W +: COEF_W] = c3[COEF_W-1:0];
        v[4*COEF_W +: COEF_W] = c4[COEF_W-1:0];
        v[5*COEF_W +: COEF_W] = c5[COEF_W-1:0];
        v[6*COEF_W +: COEF_W] = c6[COEF_W-1:0];
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Accept one vector, then wait (bounded) for out_valid; out is left presented.
    task automatic run_vec(input string tag, input logic [VEC_W-1:0] v);
        logic seen;
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [VEC_W-1:0] v_max, v_one, v_u3, v_all1, v_big;

    initial begin
        v_max  = vec7(9, 18, 27, 36, 27, 18, 9);
        v_one  = vec7(1, 0, 0, 0, 0, 0, 0);
        v_u3   = vec7(0, 0, 0, 5, 0, 0, 0);
        v_all1 = vec7(1, 1, 1, 1, 1, 1, 1);
        v_big  = vec7(0, 0, 0, 0, 0, 0, 4095);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
`ifdef SSA_COMBINE_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Max product with exact latency.
        in_vec   = v_max;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("max_busy_in_ready", in_ready, 0);
        chk("max_busy_out_valid", out_valid, 0);
        repeat (6) step();
        chk("max_early_out_valid", out_valid, 0);
        step();
        chk("max_out_valid", out_valid, 1);
        chk("max_out", out, 32'hFE01);
`ifdef SSA_COMBINE_OVF_EN
        chk("max_ovf", ovf, 0);
`endif
        handshake();
        chk("max_hs_out_valid", out_valid, 0);
        chk("max_hs_in_ready", in_ready, 1);

        // Unit vectors.
        run_vec("unit0", v_one);
        chk("unit0_out", out, 1);
        handshake();
        run_vec("unit3", v_u3);
        chk("unit3_out", out, 320);
        handshake();

        // Backpressure, with a different vector offered while DONE.
        run_vec("bp", v_all1);
        chk("bp_out", out, 32'h1555);
        in_vec   = v_one;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_out_valid", out_valid, 1);
            chk("bp_hold_out", out, 32'h1555);
            chk("bp_hold_in_ready", in_ready, 0);
`ifdef SSA_COMBINE_OVF_EN
            chk("bp_hold_ovf", ovf, 0);
`endif
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        // Truncation / overflow.
        run_vec("ovf", v_big);
        chk("ovf_out", out, 32'hF000);
`ifdef SSA_COMBINE_OVF_EN
        chk("ovf_flag", ovf, 1);
`endif
        handshake();
`ifdef SSA_COMBINE_OVF_EN
        chk("ovf_cleared", ovf, 0);
`endif

        // Reset in the middle of a run.
        in_vec   = v_max;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        chk("midrst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", in_ready, 1);
        run_vec("after_rst", v_max);
        chk("after_rst_out", out, 32'hFE01);
`ifdef SSA_COMBINE_OVF_EN
        chk("after_rst_ovf", ovf, 0);
`endif
        handshake();

        // Back-to-back: accepts every 9 cycles; the vector offered while busy is ignored.
        in_vec    = v_max;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 27; n++) begin
            step();
            chk("b2b_in_ready", in_ready, ((n % 9) == 8) ? 1 : 0);
            chk("b2b_out_valid", out_valid, ((n % 9) == 7) ? 1 : 0);
            if ((n % 9) == 7) chk("b2b_out", out, 32'hFE01);
            in_vec = (in_ready === 1'b1) ? v_max : v_one;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
